// File: rtl/stepper_step_generator_pkg.sv
// Shared definitions for the stepper step generator: profile states,
// default widths and the minimum step period.
package stepper_pkg;
   typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_e;

   localparam int DEFAULT_CNT_W = 16;
   localparam int DEFAULT_DIV_W = 20;
   localparam int MIN_PERIOD    = 2;
endpackage

// File: rtl/stepper_step_generator_if.sv
// Command handshake and step/status bundle between a motion master and the
// step generator.
interface stepper_step_generator_if
   import stepper_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W,
   parameter int DIV_W = DEFAULT_DIV_W
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_steps;
   logic             cmd_dir;
   logic [DIV_W-1:0] cmd_period;
   logic             abort;
   logic             step_pulse;
   logic             step_dir;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] steps_left;

   modport master (
      output cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
      input  cmd_ready, step_pulse, step_dir, busy, done, steps_left
   );

   modport slave (
      input  cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
      output cmd_ready, step_pulse, step_dir, busy, done, steps_left
   );
endinterface

// File: rtl/stepper_step_generator_step_timer.sv
// Loadable down-counter; tick_o is high while the count sits at zero.
module step_timer #(
   parameter int W = 20
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         tick_o
);
   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tick_o = (cnt_q == '0);
endmodule

// File: rtl/stepper_step_generator.sv
// Linear accelerate/cruise/decelerate step-pulse generator feeding the
// stepper phase sequencer; one pulse per step, abortable mid-move.
module stepper_step_generator
   import stepper_pkg::*;
#(
   parameter int CNT_W        = DEFAULT_CNT_W,
   parameter int DIV_W        = DEFAULT_DIV_W,
   parameter int START_PERIOD = 10,
   parameter int RAMP_DEC     = 2
) (
   input  logic                      clock_clk,
   input  logic                      reset_low,
   stepper_step_generator_if.slave   bus
);
   localparam int PW = DIV_W + 1;
   typedef logic [PW-1:0] per_t;

   localparam per_t START_W = per_t'(START_PERIOD);
   localparam per_t RAMP_W  = per_t'(RAMP_DEC);
   localparam per_t MIN_W   = per_t'(MIN_PERIOD);

   function automatic per_t pmax(input per_t a, input per_t b);
      return (a > b) ? a : b;
   endfunction

   function automatic per_t pmin(input per_t a, input per_t b);
      return (a < b) ? a : b;
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] steps_left_q, steps_left_d;
   logic [CNT_W-1:0] ramp_q, ramp_d;
   per_t             cruise_q, cruise_d;
   per_t             start_q, start_d;
   per_t             cur_q, cur_d;
   logic             dir_q, dir_d;
   logic             done_q, done_d;

   logic             accept;
   logic             tmr_load, tmr_tick;
   logic [DIV_W-1:0] tmr_val;
   per_t             cruise_w, start_w, up_w, dn_w, next_w;
   logic [CNT_W-1:0] sl_dec, ramp_dn;

   step_timer #(.W(DIV_W)) u_timer (
      .clk_i      (clock_clk),
      .rst_ni     (reset_low),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (state_q != IDLE),
      .tick_o     (tmr_tick)
   );

   assign bus.cmd_ready  = reset_low && (state_q == IDLE) && !bus.abort;
   assign accept         = bus.cmd_valid && bus.cmd_ready;
   assign bus.step_pulse = tmr_tick && (state_q != IDLE) && !bus.abort;
   assign bus.busy       = (state_q != IDLE);
   assign bus.step_dir   = dir_q;
   assign bus.done       = done_q;
   assign bus.steps_left = steps_left_q;

   always_ff @(posedge clock_clk or negedge reset_low) begin
      if (!reset_low) begin
         state_q      <= IDLE;
         steps_left_q <= '0;
         ramp_q       <= '0;
         cruise_q     <= '0;
         start_q      <= '0;
         cur_q        <= '0;
         dir_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         steps_left_q <= steps_left_d;
         ramp_q       <= ramp_d;
         cruise_q     <= cruise_d;
         start_q      <= start_d;
         cur_q        <= cur_d;
         dir_q        <= dir_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      steps_left_d = steps_left_q;
      ramp_d       = ramp_q;
      cruise_d     = cruise_q;
      start_d      = start_q;
      cur_d        = cur_q;
      dir_d        = dir_q;
      done_d       = 1'b0;
      tmr_load     = 1'b0;
      tmr_val      = '0;
      cruise_w     = pmax(per_t'(bus.cmd_period), MIN_W);
      start_w      = pmax(START_W, cruise_w);
      sl_dec       = steps_left_q - 1'b1;
      ramp_dn      = (ramp_q == '0) ? '0 : ramp_q - 1'b1;
      up_w         = pmin(cur_q + RAMP_W, start_q);
      // Compare before subtracting so the period never wraps below cruise.
      dn_w         = (cur_q > cruise_q + RAMP_W) ? cur_q - RAMP_W : cruise_q;
      next_w       = cur_q;

      if (state_q == IDLE) begin
         if (accept) begin
            dir_d        = bus.cmd_dir;
            steps_left_d = bus.cmd_steps;
            cruise_d     = cruise_w;
            start_d      = start_w;
            cur_d        = start_w;
            ramp_d       = '0;
            tmr_load     = 1'b1;
            tmr_val      = DIV_W'(start_w - per_t'(1));
            if (bus.cmd_steps == '0) done_d = 1'b1;
            else                     state_d = ACCEL;
         end
      end else if (bus.abort) begin
         state_d = IDLE;
         done_d  = 1'b1;
      end else if (tmr_tick) begin
         steps_left_d = sl_dec;
         if (sl_dec == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end else if ((sl_dec <= ramp_q) && (state_q != DECEL)) begin
            state_d = DECEL;
            next_w  = up_w;
            ramp_d  = ramp_dn;
         end else begin
            case (state_q)
               ACCEL: begin
                  next_w = dn_w;
                  if (dn_w < cur_q)     ramp_d  = ramp_q + 1'b1;
                  if (dn_w == cruise_q) state_d = CRUISE;
               end
               DECEL: begin
                  next_w = up_w;
                  ramp_d = ramp_dn;
               end
               default: next_w = cur_q;
            endcase
         end
         cur_d    = next_w;
         tmr_load = 1'b1;
         tmr_val  = DIV_W'(next_w - per_t'(1));
      end
   end
endmodule

// File: tb/tb_stepper_step_generator.sv
// Directed bench for stepper_step_generator: profile gaps, done/busy timing,
// abort, period clamping and asynchronous reset mid-move.
module tb_stepper_step_generator;
   logic clk = 1'b0;
   logic rst_n;

   stepper_step_generator_if #(.CNT_W(16), .DIV_W(20)) bus();

   stepper_step_generator #(
      .CNT_W(16), .DIV_W(20), .START_PERIOD(10), .RAMP_DEC(2)
   ) dut (
      .clock_clk (clk),
      .reset_low (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int          pulses[$];
   int          done_cyc;
   int          dir_bad, dbl_bad, busy_bad;
   logic        ready_abort;
   logic        ready_done;
   logic [15:0] sl_at_done;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_gaps(input string tag, input int exp[$]);
      int g;
      chk({tag, "_npulse"}, pulses.size(), exp.size());
      for (int i = 0; i < exp.size(); i++) begin
         if (i >= pulses.size()) g = -1;
         else if (i == 0)        g = pulses[0];
         else                    g = pulses[i] - pulses[i-1];
         chk($sformatf("%s_gap%0d", tag, i), g, exp[i]);
      end
   endtask

   // Accept at the end of cycle 0; cycle k is sampled on its falling edge.
   task automatic run_move(input int steps, input int period, input bit dir,
                           input int abort_at, input int limit);
      bit prev;
      prev = 1'b0;
      pulses.delete();
      done_cyc = -1; dir_bad = 0; dbl_bad = 0; busy_bad = 0;
      ready_abort = 1'b0; ready_done = 1'b0; sl_at_done = '0;
      @(negedge clk);
      bus.cmd_steps  = 16'(steps);
      bus.cmd_period = 20'(period);
      bus.cmd_dir    = dir;
      bus.cmd_valid  = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      for (int k = 1; k <= limit; k++) begin
         if (k == abort_at) bus.abort = 1'b1;
         @(negedge clk);
         if (bus.step_pulse) begin
            pulses.push_back(k);
            if (prev) dbl_bad++;
         end
         prev = bus.step_pulse;
         if (bus.abort && bus.cmd_ready) ready_abort = 1'b1;
         if (bus.busy && (bus.step_dir !== dir)) dir_bad++;
         if (bus.done) begin
            done_cyc   = k;
            sl_at_done = bus.steps_left;
            ready_done = bus.cmd_ready;
            if (bus.busy) busy_bad++;
         end else if (bus.busy !== (steps != 0)) begin
            busy_bad++;
         end
         @(posedge clk); #1;
         bus.abort = 1'b0;
         if (done_cyc >= 0) break;
      end
   endtask

   int gaps_full[$]  = '{10, 8, 6, 4, 4, 4, 4, 6, 8, 10};
   int gaps_tri[$]   = '{10, 8, 10};
   int gaps_abort[$] = '{10, 8};
   int gaps_slow[$]  = '{20, 20, 20};
   int gaps_min[$]   = '{10, 8, 6, 4, 2, 4, 6, 8};
   int gaps_none[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt_done, cnt_pulse;
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_steps = '0; bus.cmd_dir = 1'b0;
      bus.cmd_period = '0; bus.abort = 1'b0;
      #2;
      chk("rst_ready", bus.cmd_ready, 0);
      chk("rst_pulse", bus.step_pulse, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_sl", bus.steps_left, 0);
      chk("rst_dir", bus.step_dir, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", bus.cmd_ready, 1);
      bus.abort = 1'b1; #1;
      chk("idle_abort_ready", bus.cmd_ready, 0);
      bus.abort = 1'b0;

      // Full accel/cruise/decel profile
      run_move(10, 4, 1'b1, -1, 200);
      chk_gaps("full", gaps_full);
      chk("full_last", (pulses.size() > 0) ? pulses[$] : -1, 64);
      chk("full_done", done_cyc, 65);
      chk("full_dir", dir_bad, 0);
      chk("full_busy", busy_bad, 0);
      chk("full_dbl", dbl_bad, 0);
      chk("full_ready_done", ready_done, 1);
      chk("full_sl_done", sl_at_done, 0);

      // Triangle move, reverse direction, back-to-back with the previous done
      run_move(3, 4, 1'b0, -1, 200);
      chk_gaps("tri", gaps_tri);
      chk("tri_done", done_cyc, 29);
      chk("tri_dir", dir_bad, 0);
      chk("tri_busy", busy_bad, 0);

      // Zero-step command
      run_move(0, 4, 1'b1, -1, 50);
      chk_gaps("zero", gaps_none);
      chk("zero_done", done_cyc, 1);
      chk("zero_busy", busy_bad, 0);

      // Abort when the third pulse is due
      run_move(10, 4, 1'b1, 24, 200);
      chk_gaps("abort", gaps_abort);
      chk("abort_done", done_cyc, 25);
      chk("abort_sl", sl_at_done, 8);
      chk("abort_ready", ready_abort, 0);
      chk("abort_busy", busy_bad, 0);

      // Cruise slower than the start period
      run_move(3, 20, 1'b1, -1, 200);
      chk_gaps("slow", gaps_slow);
      chk("slow_done", done_cyc, 61);

      // Period 0 clamps to the minimum of 2
      run_move(8, 0, 1'b1, -1, 200);
      chk_gaps("min", gaps_min);
      chk("min_done", done_cyc, 49);
      chk("min_dbl", dbl_bad, 0);

      // Asynchronous reset while a pulse is on the output
      @(negedge clk);
      bus.cmd_steps = 16'd10; bus.cmd_period = 20'd4; bus.cmd_dir = 1'b1;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      chk("prerst_pulse", bus.step_pulse, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pulse", bus.step_pulse, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_sl", bus.steps_left, 0);
      chk("mid_rst_dir", bus.step_dir, 0);
      chk("mid_rst_ready", bus.cmd_ready, 0);
      chk("mid_rst_done", bus.done, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      cnt_done = 0; cnt_pulse = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) cnt_done++;
         if (bus.step_pulse) cnt_pulse++;
      end
      chk("post_rst_done", cnt_done, 0);
      chk("post_rst_pulse", cnt_pulse, 0);

      run_move(10, 4, 1'b1, -1, 200);
      chk_gaps("again", gaps_full);
      chk("again_done", done_cyc, 65);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
